conv_layer_seq: RTL and testbench

Sequential fixed-point 2-D convolution layer with "same" zero padding.
- Holds input feature map, kernels and biases in internal register memories, loaded through a write port.
- Computes each output pixel with a single time-multiplexed MAC and streams results out over a valid/ready interface.
- Optional ReLU and saturating output.
- Replaces the combinational convolution array in the CNN datapath. Area scales with memory size, not with OUT_DEPTH*H*W MAC units.

---
 rtl/conv_layer_seq_pkg.sv | 32 +++
 rtl/conv_layer_seq_if.sv | 32 +++
 rtl/conv_layer_seq_fxp_mac.sv | 47 ++++
 rtl/conv_layer_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_conv_layer_seq.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_layer_seq_pkg.sv
// Shared types, load-port encodings and fixed-point helpers for the sequential
// convolution layer.
package conv_pkg;

  localparam logic [1:0] LD_INPUT  = 2'd0;
  localparam logic [1:0] LD_KERNEL = 2'd1;
  localparam logic [1:0] LD_BIAS   = 2'd2;

  // Widest accumulator the saturation helper supports.
  localparam int unsigned MaxAccW = 64;

  typedef enum logic [1:0] {StIdle, StMac, StEmit, StDone} conv_state_e;

  // Width of a counter/index over n items, never below one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Arithmetic shift right by frac (floor), then clamp to a data_w-bit signed range.
  function automatic logic signed [MaxAccW-1:0] sat_shift(input logic signed [MaxAccW-1:0] acc,
                                                           input int unsigned frac,
                                                           input int unsigned data_w);
    logic signed [MaxAccW-1:0] sh, hi, lo;
    sh = acc >>> frac;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (sh > hi) return hi;
    if (sh < lo) return lo;
    return sh;
  endfunction

endpackage

// File: rtl/conv_layer_seq_if.sv
// Load port, control and streaming output of the convolution layer.
interface conv_layer_seq_if #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned AW     = 10,
  parameter int unsigned CH_W   = 5,
  parameter int unsigned ROW_W  = 3,
  parameter int unsigned COL_W  = 3
);
  logic                     ld_en;
  logic [1:0]               ld_sel;
  logic [AW-1:0]            ld_addr;
  logic signed [DATA_W-1:0] ld_data;
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [CH_W-1:0]          out_ch;
  logic [ROW_W-1:0]         out_row;
  logic [COL_W-1:0]         out_col;

  modport master (
    output ld_en, ld_sel, ld_addr, ld_data, start, out_ready,
    input  busy, done, out_valid, out_data, out_ch, out_row, out_col
  );

  modport slave (
    input  ld_en, ld_sel, ld_addr, ld_data, start, out_ready,
    output busy, done, out_valid, out_data, out_ch, out_row, out_col
  );
endinterface

// File: rtl/conv_layer_seq_fxp_mac.sv
// Single fixed-point multiply-accumulate with bias preload, saturating output and
// optional ReLU.
module fxp_mac
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned FRAC   = 9,
  parameter int unsigned ACC_W  = 48,
  parameter int unsigned RELU   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic signed [DATA_W-1:0] bias_i,
  input  logic                     acc_en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] res_o
);
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0]   sat_res;

  always_comb begin
    prod  = a_i * b_i;
    acc_d = acc_q;
    if (load_i) begin
      acc_d = ACC_W'(bias_i) <<< FRAC;
    end else if (acc_en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_comb begin
    sat_res = DATA_W'(sat_shift(MaxAccW'(acc_q), FRAC, DATA_W));
    res_o   = (RELU != 0 && sat_res < 0) ? '0 : sat_res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/conv_layer_seq.sv
// Sequential "same"-padded 2-D convolution: register memories, one time-multiplexed
// MAC and a valid/ready result stream in cout-major, row, column order.
module conv_layer_seq
  import conv_pkg::*;
#(
  parameter int unsigned IN_DEPTH    = 2,
  parameter int unsigned IN_HEIGHT   = 5,
  parameter int unsigned IN_WIDTH    = 5,
  parameter int unsigned OUT_DEPTH   = 32,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned DATA_W      = 18,
  parameter int unsigned FRAC        = 9,
  parameter int unsigned ACC_W       = 48,
  parameter int unsigned RELU        = 0
) (
  input logic             clk,
  input logic             rst,
  conv_layer_seq_if.slave bus
);
  localparam int          PAD     = int'(KERNEL_SIZE / 2);
  localparam int unsigned IN_SIZE = IN_DEPTH * IN_HEIGHT * IN_WIDTH;
  localparam int unsigned K_SIZE  = OUT_DEPTH * IN_DEPTH * KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned IN_AW   = clog2_min1(IN_SIZE);
  localparam int unsigned K_AW    = clog2_min1(K_SIZE);
  localparam int unsigned CH_W    = clog2_min1(OUT_DEPTH);
  localparam int unsigned ROW_W   = clog2_min1(IN_HEIGHT);
  localparam int unsigned COL_W   = clog2_min1(IN_WIDTH);
  localparam int unsigned CIN_W   = clog2_min1(IN_DEPTH);
  localparam int unsigned KS_W    = clog2_min1(KERNEL_SIZE);

  logic signed [DATA_W-1:0] in_mem [IN_SIZE];
  logic signed [DATA_W-1:0] k_mem  [K_SIZE];
  logic signed [DATA_W-1:0] b_mem  [OUT_DEPTH];

  conv_state_e              state_q, state_d;
  logic [CIN_W-1:0]         cin_q, cin_d;
  logic [KS_W-1:0]          kh_q, kh_d, kw_q, kw_d;
  logic [CH_W-1:0]          cout_q, cout_d, cout_nx;
  logic [ROW_W-1:0]         r_q, r_d, r_nx;
  logic [COL_W-1:0]         c_q, c_d, c_nx;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]          out_ch_q, out_ch_d;
  logic [ROW_W-1:0]         out_row_q, out_row_d;
  logic [COL_W-1:0]         out_col_q, out_col_d;

  logic                     mac_load, mac_en, tap_ok, last_tap, last_pix;
  logic [CH_W-1:0]          bias_sel;
  logic [IN_AW-1:0]         in_idx;
  logic [K_AW-1:0]          k_idx;
  logic signed [DATA_W-1:0] tap_in, tap_k, mac_res;

  // Memories keep their contents across reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (state_q == StIdle && bus.ld_en) begin
      case (bus.ld_sel)
        LD_INPUT:  if (32'(bus.ld_addr) < IN_SIZE)   in_mem[IN_AW'(bus.ld_addr)] <= bus.ld_data;
        LD_KERNEL: if (32'(bus.ld_addr) < K_SIZE)    k_mem[K_AW'(bus.ld_addr)]   <= bus.ld_data;
        LD_BIAS:   if (32'(bus.ld_addr) < OUT_DEPTH) b_mem[CH_W'(bus.ld_addr)]   <= bus.ld_data;
        default: ;
      endcase
    end
  end

  // Tap fetch; taps falling in the padding border read as zero.
  always_comb begin
    int ir, ic;
    ir     = int'(r_q) + int'(kh_q) - PAD;
    ic     = int'(c_q) + int'(kw_q) - PAD;
    tap_ok = ir >= 0 && ir < int'(IN_HEIGHT) && ic >= 0 && ic < int'(IN_WIDTH);
    in_idx = IN_AW'((int'(cin_q) * int'(IN_HEIGHT) + ir) * int'(IN_WIDTH) + ic);
    k_idx  = K_AW'(((int'(cout_q) * int'(IN_DEPTH) + int'(cin_q)) * int'(KERNEL_SIZE)
                    + int'(kh_q)) * int'(KERNEL_SIZE) + int'(kw_q));
    tap_in = tap_ok ? in_mem[in_idx] : '0;
    tap_k  = k_mem[k_idx];
  end

  assign last_tap = (cin_q == CIN_W'(IN_DEPTH - 1)) && (kh_q == KS_W'(KERNEL_SIZE - 1)) &&
                    (kw_q == KS_W'(KERNEL_SIZE - 1));
  assign last_pix = (cout_q == CH_W'(OUT_DEPTH - 1)) && (r_q == ROW_W'(IN_HEIGHT - 1)) &&
                    (c_q == COL_W'(IN_WIDTH - 1));

  always_comb begin
    c_nx    = c_q + COL_W'(1);
    r_nx    = r_q;
    cout_nx = cout_q;
    if (c_q == COL_W'(IN_WIDTH - 1)) begin
      c_nx = '0;
      if (r_q == ROW_W'(IN_HEIGHT - 1)) begin
        r_nx    = '0;
        cout_nx = cout_q + CH_W'(1);
      end else begin
        r_nx = r_q + ROW_W'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cin_d       = cin_q;
    kh_d        = kh_q;
    kw_d        = kw_q;
    cout_d      = cout_q;
    r_d         = r_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    mac_load    = 1'b0;
    mac_en      = 1'b0;
    bias_sel    = cout_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d  = StMac;
          cin_d    = '0;
          kh_d     = '0;
          kw_d     = '0;
          cout_d   = '0;
          r_d      = '0;
          c_d      = '0;
          bias_sel = '0;
          mac_load = 1'b1;
        end
      end
      StMac: begin
        mac_en = 1'b1;
        kw_d   = kw_q + KS_W'(1);
        if (kw_q == KS_W'(KERNEL_SIZE - 1)) begin
          kw_d = '0;
          kh_d = kh_q + KS_W'(1);
          if (kh_q == KS_W'(KERNEL_SIZE - 1)) begin
            kh_d  = '0;
            cin_d = (cin_q == CIN_W'(IN_DEPTH - 1)) ? '0 : cin_q + CIN_W'(1);
          end
        end
        if (last_tap) state_d = StEmit;
      end
      StEmit: begin
        // First EMIT cycle registers the finished accumulator; later cycles wait for ready.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = mac_res;
          out_ch_d    = cout_q;
          out_row_d   = r_q;
          out_col_d   = c_q;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (last_pix) begin
            state_d = StDone;
          end else begin
            cout_d   = cout_nx;
            r_d      = r_nx;
            c_d      = c_nx;
            bias_sel = cout_nx;
            mac_load = 1'b1;
            state_d  = StMac;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cin_q       <= '0;
      kh_q        <= '0;
      kw_q        <= '0;
      cout_q      <= '0;
      r_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      cin_q       <= cin_d;
      kh_q        <= kh_d;
      kw_q        <= kw_d;
      cout_q      <= cout_d;
      r_q         <= r_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  fxp_mac #(
    .DATA_W(DATA_W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W),
    .RELU  (RELU)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .load_i  (mac_load),
    .bias_i  (b_mem[bias_sel]),
    .acc_en_i(mac_en),
    .a_i     (tap_in),
    .b_i     (tap_k),
    .res_o   (mac_res)
  );

  assign bus.busy      = (state_q == StMac) || (state_q == StEmit);
  assign bus.done      = (state_q == StDone);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;

endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed bench: two 1x3x3 -> 2-channel layers (ReLU off/on) driven in lockstep.
module tb_conv_layer_seq;
  import conv_pkg::*;

  localparam int unsigned DW   = 18;
  localparam int unsigned AW   = 5;
  localparam int          NPIX = 18;

  logic clk, rst;
  int   n_tests, n_fail;

  conv_layer_seq_if #(.DATA_W(DW), .AW(AW), .CH_W(1), .ROW_W(2), .COL_W(2)) bus0 ();
  conv_layer_seq_if #(.DATA_W(DW), .AW(AW), .CH_W(1), .ROW_W(2), .COL_W(2)) bus1 ();

  conv_layer_seq #(
    .IN_DEPTH(1), .IN_HEIGHT(3), .IN_WIDTH(3), .OUT_DEPTH(2), .KERNEL_SIZE(3),
    .DATA_W(DW), .FRAC(9), .ACC_W(48), .RELU(0)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  conv_layer_seq #(
    .IN_DEPTH(1), .IN_HEIGHT(3), .IN_WIDTH(3), .OUT_DEPTH(2), .KERNEL_SIZE(3),
    .DATA_W(DW), .FRAC(9), .ACC_W(48), .RELU(1)
  ) u_relu (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [DW-1:0] got0 [NPIX];
  logic signed [DW-1:0] got1 [NPIX];
  logic [4:0]           got_pos [NPIX];
  logic signed [DW-1:0] exp0 [NPIX];
  int n_xfer, n_done, first_valid, unstable;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_ld(input logic en, input logic [1:0] sel, input logic [AW-1:0] addr,
                        input logic signed [DW-1:0] d);
    bus0.ld_en = en; bus0.ld_sel = sel; bus0.ld_addr = addr; bus0.ld_data = d;
    bus1.ld_en = en; bus1.ld_sel = sel; bus1.ld_addr = addr; bus1.ld_data = d;
  endtask

  task automatic set_start(input logic v);
    bus0.start = v;
    bus1.start = v;
  endtask

  task automatic set_ready(input logic v);
    bus0.out_ready = v;
    bus1.out_ready = v;
  endtask

  task automatic load(input logic [1:0] sel, input int addr, input int d);
    @(negedge clk);
    set_ld(1'b1, sel, AW'(addr), DW'(d));
    @(negedge clk);
    set_ld(1'b0, 2'd0, '0, '0);
  endtask

  task automatic fill(input logic [1:0] sel, input int n, input int d);
    for (int i = 0; i < n; i++) load(sel, i, d);
  endtask

  // Expected output for all-ones input and kernel: 1.0 per in-bounds tap.
  function automatic int ones_px(input int p);
    int r, c;
    r = (p % 9) / 3;
    c = p % 3;
    return ((r == 1) ? 3 : 2) * ((c == 1) ? 3 : 2) * 512;
  endfunction

  task automatic run_layer(input bit rnd, input bit poke);
    int  stall, tail;
    logic rdy, prev_stall;
    logic signed [DW-1:0] prev_data;
    logic [4:0] prev_pos, pos;
    n_xfer = 0; n_done = 0; first_valid = -1; unstable = 0;
    stall = 0; tail = 0; prev_stall = 1'b0; prev_data = '0; prev_pos = '0;
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    for (int cyc = 0; cyc < 3000 && tail < 4; cyc++) begin
      if (!rnd) begin
        rdy = 1'b1;
      end else if (stall > 0) begin
        rdy = 1'b0;
        stall--;
      end else if ($urandom_range(0, 7) == 0) begin
        rdy = 1'b0;
        stall = 9;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      set_ready(rdy);
      if (poke && cyc == 20) begin
        set_ld(1'b1, LD_INPUT, 5'd4, 18'sd5000);
        set_start(1'b1);
      end
      if (poke && cyc == 21) begin
        set_ld(1'b0, 2'd0, '0, '0);
        set_start(1'b0);
      end
      pos = {bus0.out_ch, bus0.out_row, bus0.out_col};
      if (bus0.out_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall && (!bus0.out_valid || bus0.out_data !== prev_data || pos !== prev_pos))
        unstable++;
      prev_stall = bus0.out_valid && !rdy;
      prev_data  = bus0.out_data;
      prev_pos   = pos;
      if (bus0.out_valid && rdy) begin
        if (n_xfer < NPIX) begin
          got0[n_xfer]    = bus0.out_data;
          got1[n_xfer]    = bus1.out_data;
          got_pos[n_xfer] = pos;
        end
        n_xfer++;
      end
      if (bus0.done) n_done++;
      if (n_done > 0) tail++;
      @(negedge clk);
    end
    set_ready(1'b0);
  endtask

  task automatic check_seq(input string tag);
    logic [4:0] ep;
    check($sformatf("%s_xfers", tag), n_xfer, NPIX);
    check($sformatf("%s_done", tag), n_done, 1);
    check($sformatf("%s_busy_end", tag), bus0.busy, 0);
    for (int p = 0; p < NPIX; p++) begin
      ep = {1'(p / 9), 2'((p % 9) / 3), 2'(p % 3)};
      check($sformatf("%s_px%0d", tag, p), got0[p], exp0[p]);
      check($sformatf("%s_pos%0d", tag, p), got_pos[p], ep);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, dn;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    set_ld(1'b0, 2'd0, '0, '0);
    set_start(1'b0);
    set_ready(1'b0);
    repeat (3) @(negedge clk);
    check("rst_busy", bus0.busy, 0);
    check("rst_done", bus0.done, 0);
    check("rst_valid", bus0.out_valid, 0);
    check("rst_data", bus0.out_data, 0);
    check("rst_pos", {bus0.out_ch, bus0.out_row, bus0.out_col}, 0);
    rst = 1'b0;

    // All ones: corners 4.0, edges 6.0, centre 9.0; first valid 10 cycles after start.
    fill(LD_INPUT, 9, 512);
    fill(LD_KERNEL, 18, 512);
    fill(LD_BIAS, 2, 0);
    run_layer(1'b0, 1'b0);
    check("t1_latency", first_valid, 10);
    for (int p = 0; p < NPIX; p++) exp0[p] = DW'(ones_px(p));
    check_seq("t1");

    // Bias only: channel 1 bias 0.5.
    fill(LD_INPUT, 9, 0);
    load(LD_BIAS, 1, 256);
    run_layer(1'b0, 1'b0);
    for (int p = 0; p < NPIX; p++) exp0[p] = (p < 9) ? 18'sd0 : 18'sd256;
    check_seq("t2");

    // Saturation both ways.
    load(LD_BIAS, 1, 0);
    fill(LD_INPUT, 9, 51200);
    run_layer(1'b0, 1'b0);
    for (int p = 0; p < NPIX; p++) exp0[p] = 18'sd131071;
    check_seq("t3_satpos");
    fill(LD_INPUT, 9, -51200);
    run_layer(1'b0, 1'b0);
    for (int p = 0; p < NPIX; p++) exp0[p] = -18'sd131072;
    check_seq("t3_satneg");

    // -1 LSB times 0.5 floors to -1 at the centre pixel of channel 0.
    fill(LD_INPUT, 9, 0);
    load(LD_INPUT, 4, -1);
    fill(LD_KERNEL, 18, 0);
    load(LD_KERNEL, 4, 256);
    run_layer(1'b0, 1'b0);
    for (int p = 0; p < NPIX; p++) exp0[p] = (p == 4) ? -18'sd1 : 18'sd0;
    check_seq("t3_floor");

    // Negative kernels: plain instance goes negative, ReLU instance clamps to zero.
    fill(LD_INPUT, 9, 512);
    fill(LD_KERNEL, 18, -512);
    run_layer(1'b0, 1'b0);
    for (int p = 0; p < NPIX; p++) exp0[p] = DW'(-ones_px(p));
    check_seq("t4_norelu");
    for (int p = 0; p < NPIX; p++) check($sformatf("t4_relu_px%0d", p), got1[p], 0);

    // Random backpressure with a load and a start attempted while busy.
    fill(LD_KERNEL, 18, 512);
    run_layer(1'b1, 1'b1);
    for (int p = 0; p < NPIX; p++) exp0[p] = DW'(ones_px(p));
    check_seq("t5");
    check("t5_stable", unstable, 0);

    // Reset in the middle of pixel 7, then a clean rerun from retained memories.
    @(negedge clk);
    set_start(1'b1);
    set_ready(1'b1);
    @(negedge clk);
    set_start(1'b0);
    cnt = 0;
    dn  = 0;
    for (int i = 0; i < 2000 && cnt < 7; i++) begin
      if (bus0.out_valid) cnt++;
      if (bus0.done) dn++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("t6_pre_cnt", cnt, 7);
    check("t6_pre_busy", bus0.busy, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_busy", bus0.busy, 0);
    check("t6_rst_valid", bus0.out_valid, 0);
    check("t6_rst_done", bus0.done, 0);
    check("t6_no_done", dn, 0);
    @(negedge clk);
    rst = 1'b0;
    run_layer(1'b0, 1'b0);
    check_seq("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
